// File: rtl/ultrasonido_pkg.sv
// rtl/ultrasonido_pkg.sv - shared states, widths, default timings and channel search for the ultrasonic scheduler
package ultrasonido_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT,
    FLUSH,
    WFLUSH,
    GAP
  } state_e;

  localparam int DIST_W          = 9;
  localparam int MAX_CH          = 8;
  localparam int DEF_INIT_HOLD   = 200;
  localparam int DEF_TIMEOUT_CYC = 3_000_000;
  localparam int DEF_FLUSH_CYC   = 200;
  localparam int DEF_GAP_CYC     = 6_000_000;

  // Lowest set bit at index >= from; bit 3 of the result flags "none found".
  function automatic logic [3:0] next_set(input logic [MAX_CH-1:0] mask, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd8;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ultrasonido_sync2.sv
// rtl/ultrasonido_sync2.sv - two-flop synchroniser for one asynchronous bit
module ultrasonido_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ultrasonido_scheduler.sv
// rtl/ultrasonido_scheduler.sv - round-robin sharing of one ranging engine across N_CH sensors
module ultrasonido_scheduler
  import ultrasonido_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int INIT_HOLD   = DEF_INIT_HOLD,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int FLUSH_CYC   = DEF_FLUSH_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [N_CH-1:0]        chan_mask,
  output logic                   eng_init,
  input  logic                   eng_done,
  input  logic [DIST_W-1:0]      eng_distance,
  input  logic                   eng_trig,
  output logic                   eng_echo,
  output logic [N_CH-1:0]        trig,
  input  logic [N_CH-1:0]        echo,
  output logic [DIST_W*N_CH-1:0] distance,
  output logic [N_CH-1:0]        valid,
  output logic [N_CH-1:0]        timeout,
  output logic                   busy,
  output logic                   scan_done
);

  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [2:0]                    sel_q, sel_d;
  logic [N_CH-1:0]               mask_q, mask_d;
  logic [N_CH-1:0]               valid_q, valid_d;
  logic [N_CH-1:0]               timeout_q, timeout_d;
  logic [N_CH-1:0][DIST_W-1:0]   dist_q, dist_d;
  logic                          busy_q, busy_d;
  logic                          scan_done_q, scan_done_d;
  logic                          done_prev_q;
  logic                          done_s;
  logic                          done_rise;
  logic [N_CH-1:0]               echo_s;
  logic                          sel_echo;
  logic [3:0]                    lowest_new;
  logic [3:0]                    nxt;

  ultrasonido_sync2 u_done_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (eng_done),
    .q_o   (done_s)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_echo_sync
    ultrasonido_sync2 u_echo_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (echo[g]),
      .q_o   (echo_s[g])
    );
  end

  assign done_rise  = done_s & ~done_prev_q;
  assign lowest_new = next_set(MAX_CH'(chan_mask), 4'd0);
  assign nxt        = next_set(MAX_CH'(mask_q), {1'b0, sel_q} + 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      mask_q      <= '0;
      valid_q     <= '0;
      timeout_q   <= '0;
      dist_q      <= '0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      mask_q      <= mask_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      dist_q      <= dist_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
      done_prev_q <= done_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    mask_d      = mask_q;
    valid_d     = valid_q;
    timeout_d   = timeout_q;
    dist_d      = dist_q;
    busy_d      = busy_q;
    scan_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mask_d = chan_mask;
          if (lowest_new[3]) begin
            scan_done_d = 1'b1;
          end else begin
            busy_d    = 1'b1;
            valid_d   = '0;
            timeout_d = '0;
            sel_d     = lowest_new[2:0];
            cnt_d     = '0;
            state_d   = INIT;
          end
        end
      end
      INIT: begin
        if (cnt_q == INIT_LAST) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (done_rise) begin
          for (int i = 0; i < N_CH; i++) begin
            if (sel_q == 3'(i)) begin
              dist_d[i]  = eng_distance;
              valid_d[i] = 1'b1;
            end
          end
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q == TO_LAST) begin
          for (int i = 0; i < N_CH; i++) begin
            if (sel_q == 3'(i)) timeout_d[i] = 1'b1;
          end
          cnt_d   = '0;
          state_d = FLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = WFLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // The engine's answer to the forced echo is stale, so it is dropped.
      WFLUSH: begin
        if (done_rise || (cnt_q == TO_LAST)) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!nxt[3]) begin
            sel_d   = nxt[2:0];
            state_d = INIT;
          end else begin
            scan_done_d = 1'b1;
            if (continuous) begin
              mask_d    = chan_mask;
              valid_d   = '0;
              timeout_d = '0;
              if (lowest_new[3]) begin
                busy_d  = 1'b0;
                state_d = IDLE;
              end else begin
                sel_d   = lowest_new[2:0];
                state_d = INIT;
              end
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_echo = 1'b0;
    trig     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_q == 3'(i)) begin
        sel_echo = echo_s[i];
        trig[i]  = eng_trig & ((state_q == INIT) || (state_q == WAIT));
      end
    end
    eng_init = (state_q == INIT);
    case (state_q)
      INIT, WAIT: eng_echo = sel_echo;
      FLUSH:      eng_echo = 1'b1;
      default:    eng_echo = 1'b0;
    endcase
  end

  assign distance  = dist_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_ultrasonido_scheduler.sv
// tb/tb_ultrasonido_scheduler.sv - bench with engine and sensor models for ultrasonido_scheduler
module tb_ultrasonido_scheduler;

  localparam int N_CH        = 3;
  localparam int INIT_HOLD   = 4;
  localparam int TIMEOUT_CYC = 200;
  localparam int FLUSH_CYC   = 5;
  localparam int GAP_CYC     = 50;
  localparam int SCAN_LIMIT  = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [2:0]  chan_mask = 3'b000;
  logic        eng_init;
  logic        eng_done = 1'b0;
  logic [8:0]  eng_distance = 9'd0;
  logic        eng_trig = 1'b0;
  logic        eng_echo;
  logic [2:0]  trig;
  logic [2:0]  echo = 3'b000;
  logic [26:0] distance;
  logic [2:0]  valid;
  logic [2:0]  timeout;
  logic        busy;
  logic        scan_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ultrasonido_scheduler #(
    .N_CH        (N_CH),
    .INIT_HOLD   (INIT_HOLD),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FLUSH_CYC   (FLUSH_CYC),
    .GAP_CYC     (GAP_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .continuous   (continuous),
    .chan_mask    (chan_mask),
    .eng_init     (eng_init),
    .eng_done     (eng_done),
    .eng_distance (eng_distance),
    .eng_trig     (eng_trig),
    .eng_echo     (eng_echo),
    .trig         (trig),
    .echo         (echo),
    .distance     (distance),
    .valid        (valid),
    .timeout      (timeout),
    .busy         (busy),
    .scan_done    (scan_done)
  );

  // Ranging engine: init restarts it, then trig, wait for echo, distance = echo cycles / 2.
  int e_st = 0;
  int e_cnt = 0;
  always @(negedge clk) begin
    if (eng_init) begin
      e_st     <= 1;
      eng_done <= 1'b0;
      eng_trig <= 1'b0;
    end else begin
      case (e_st)
        1: begin e_st <= 2; e_cnt <= 3; eng_trig <= 1'b1; end
        2: begin
          e_cnt <= e_cnt - 1;
          if (e_cnt == 1) begin eng_trig <= 1'b0; e_st <= 3; end
        end
        3: if (eng_echo) begin e_st <= 4; e_cnt <= 1; end
        4: begin
          if (eng_echo) e_cnt <= e_cnt + 1;
          else begin eng_distance <= 9'(e_cnt / 2); eng_done <= 1'b1; e_st <= 0; end
        end
        default: ;
      endcase
    end
  end

  // Sensors: echo_len cycles of echo, 5 cycles after trig falls; 0 means never echoes.
  int echo_len[3] = '{0, 0, 0};
  int dly[3] = '{0, 0, 0};
  int hi[3] = '{0, 0, 0};
  logic [2:0] trig_d = 3'b000;
  always @(negedge clk) begin
    trig_d <= trig;
    for (int i = 0; i < 3; i++) begin
      if (trig_d[i] && !trig[i] && echo_len[i] != 0) dly[i] <= 5;
      else if (dly[i] > 1) dly[i] <= dly[i] - 1;
      else if (dly[i] == 1) begin dly[i] <= 0; hi[i] <= echo_len[i]; end
      if (hi[i] > 0) begin echo[i] <= 1'b1; hi[i] <= hi[i] - 1; end
      else echo[i] <= 1'b0;
    end
  end

  function automatic int oh_idx(input logic [2:0] t);
    case (t)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 9;
    endcase
  endfunction

  // Monotonic monitor counters; tests work with differences from a snapshot.
  int order_q[$];
  int trig_t_q[$];
  int cyc = 0;
  int sd_count = 0;
  int ee_cnt = 0;
  int init_cnt = 0;
  logic [2:0] trig_m = 3'b000;
  always @(negedge clk) begin
    cyc    <= cyc + 1;
    trig_m <= trig;
    if (trig != 3'b000 && trig_m == 3'b000) begin
      order_q.push_back(oh_idx(trig));
      trig_t_q.push_back(cyc);
    end
    if (scan_done) sd_count <= sd_count + 1;
    if (eng_echo) ee_cnt <= ee_cnt + 1;
    if (eng_init) init_cnt <= init_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] enc_from(input int base);
    logic [63:0] r;
    r = 64'd0;
    for (int k = base; k < order_q.size(); k++) r = (r << 4) | 64'(order_q[k] + 1);
    return r;
  endfunction

  function automatic logic [63:0] exp_order(input logic [2:0] m);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 3; i++) if (m[i]) r = (r << 4) | 64'(i + 1);
    return r;
  endfunction

  function automatic int min_gap_from(input int base);
    int g;
    g = 1 << 30;
    for (int k = base + 1; k < trig_t_q.size(); k++)
      if (trig_t_q[k] - trig_t_q[k-1] < g) g = trig_t_q[k] - trig_t_q[k-1];
    return g;
  endfunction

  task automatic pulse_start(input logic [2:0] m, input logic cont);
    chan_mask  = m;
    continuous = cont;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_scan(input logic [2:0] m);
    int b;
    b = sd_count;
    pulse_start(m, 1'b0);
    for (int t = 0; t < SCAN_LIMIT && sd_count == b; t++) @(negedge clk);
    chk("scan_done_seen", 64'(sd_count != b), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  mask;
    int          l0, l1, l2;
    logic [2:0]  ev, et;
    logic [26:0] ed;
    int          ee;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int b_ord, b_sd, b_ee, b_init, b_t;
    logic [8:0] mdist[3];
    logic [2:0] mv, mt, m;
    int ln[3];
    logic [63:0] e_ord;
    int e_ee;

    vecs[0] = '{3'b101, 20, 30, 40, 3'b101, 3'b000, {9'd20, 9'd0, 9'd10}, 60};
    vecs[1] = '{3'b010, 20, 0, 40, 3'b000, 3'b010, {9'd20, 9'd0, 9'd10}, FLUSH_CYC};
    vecs[2] = '{3'b010, 20, 10, 40, 3'b010, 3'b000, {9'd20, 9'd5, 9'd10}, 10};
    vecs[3] = '{3'b111, 8, 0, 30, 3'b101, 3'b010, {9'd15, 9'd5, 9'd4}, 43};
    vecs[4] = '{3'b001, 100, 0, 0, 3'b001, 3'b000, {9'd15, 9'd5, 9'd50}, 100};

    repeat (3) @(negedge clk);
    chk("rst_eng_init", 64'(eng_init), 64'd0);
    chk("rst_eng_echo", 64'(eng_echo), 64'd0);
    chk("rst_trig", 64'(trig), 64'd0);
    chk("rst_distance", 64'(distance), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_scan_done", 64'(scan_done), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      echo_len = '{vecs[v].l0, vecs[v].l1, vecs[v].l2};
      b_ord = order_q.size(); b_sd = sd_count; b_ee = ee_cnt;
      run_scan(vecs[v].mask);
      chk($sformatf("vec%0d_valid", v), 64'(valid), 64'(vecs[v].ev));
      chk($sformatf("vec%0d_timeout", v), 64'(timeout), 64'(vecs[v].et));
      chk($sformatf("vec%0d_distance", v), 64'(distance), 64'(vecs[v].ed));
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
      chk($sformatf("vec%0d_scan_done_cnt", v), 64'(sd_count - b_sd), 64'd1);
      chk($sformatf("vec%0d_eng_echo_cycles", v), 64'(ee_cnt - b_ee), 64'(vecs[v].ee));
      chk($sformatf("vec%0d_order", v), enc_from(b_ord), exp_order(vecs[v].mask));
    end

    mdist = '{9'd50, 9'd5, 9'd15};
    mv = 3'b001;
    mt = 3'b000;
    for (int r = 0; r < 20; r++) begin
      m = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) ln[i] = ($urandom_range(0, 3) == 0) ? 0 : 2 * int'($urandom_range(2, 60));
      e_ord = exp_order(m);
      e_ee = 0;
      if (m != 3'b000) begin mv = 3'b000; mt = 3'b000; end
      for (int i = 0; i < 3; i++) begin
        if (m[i]) begin
          if (ln[i] != 0) begin mdist[i] = 9'(ln[i] / 2); mv[i] = 1'b1; e_ee += ln[i]; end
          else begin mt[i] = 1'b1; e_ee += FLUSH_CYC; end
        end
      end
      echo_len = ln;
      b_ord = order_q.size(); b_sd = sd_count; b_ee = ee_cnt;
      run_scan(m);
      chk($sformatf("rnd%0d_valid", r), 64'(valid), 64'(mv));
      chk($sformatf("rnd%0d_timeout", r), 64'(timeout), 64'(mt));
      chk($sformatf("rnd%0d_distance", r), 64'(distance), 64'({mdist[2], mdist[1], mdist[0]}));
      chk($sformatf("rnd%0d_order", r), enc_from(b_ord), e_ord);
      chk($sformatf("rnd%0d_eng_echo_cycles", r), 64'(ee_cnt - b_ee), 64'(e_ee));
      chk($sformatf("rnd%0d_scan_done_cnt", r), 64'(sd_count - b_sd), 64'd1);
    end

    b_init = init_cnt;
    pulse_start(3'b000, 1'b0);
    chk("m0_scan_done", 64'(scan_done), 64'd1);
    chk("m0_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("m0_pulse_len", 64'(scan_done), 64'd0);
    repeat (20) @(negedge clk);
    chk("m0_no_init", 64'(init_cnt - b_init), 64'd0);

    echo_len = '{20, 30, 0};
    b_ord = order_q.size(); b_sd = sd_count; b_t = trig_t_q.size();
    pulse_start(3'b011, 1'b1);
    for (int t = 0; t < 2 * SCAN_LIMIT && sd_count - b_sd < 2; t++) @(negedge clk);
    chk("cont_two_scans", 64'(sd_count - b_sd), 64'd2);
    chk("cont_order_2", enc_from(b_ord), 64'h1212);
    for (int t = 0; t < SCAN_LIMIT && order_q.size() - b_ord < 5; t++) @(negedge clk);
    continuous = 1'b0;
    for (int t = 0; t < SCAN_LIMIT && sd_count - b_sd < 3; t++) @(negedge clk);
    repeat (GAP_CYC + 300) @(negedge clk);
    chk("cont_order_3", enc_from(b_ord), 64'h121212);
    chk("cont_scan_done_cnt", 64'(sd_count - b_sd), 64'd3);
    chk("cont_busy_end", 64'(busy), 64'd0);
    chk("cont_gap_ok", 64'(min_gap_from(b_t) >= GAP_CYC), 64'd1);
    chk("cont_distance", 64'(distance[17:0]), 64'({9'd15, 9'd10}));

    echo_len = '{16, 0, 24};
    b_ord = order_q.size(); b_sd = sd_count;
    pulse_start(3'b101, 1'b0);
    for (int t = 0; t < SCAN_LIMIT && order_q.size() == b_ord; t++) @(negedge clk);
    pulse_start(3'b010, 1'b0);
    for (int t = 0; t < SCAN_LIMIT && sd_count == b_sd; t++) @(negedge clk);
    repeat (GAP_CYC + 300) @(negedge clk);
    chk("busy_start_order", enc_from(b_ord), 64'h13);
    chk("busy_start_scan_done_cnt", 64'(sd_count - b_sd), 64'd1);
    chk("busy_start_busy", 64'(busy), 64'd0);
    chk("busy_start_valid", 64'(valid), 64'b101);
    chk("busy_start_distance", 64'({distance[26:18], distance[8:0]}), 64'({9'd12, 9'd8}));

    echo_len = '{20, 0, 0};
    b_ord = order_q.size();
    pulse_start(3'b001, 1'b0);
    for (int t = 0; t < SCAN_LIMIT && order_q.size() == b_ord; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_eng_init", 64'(eng_init), 64'd0);
    chk("arst_eng_echo", 64'(eng_echo), 64'd0);
    chk("arst_trig", 64'(trig), 64'd0);
    chk("arst_distance", 64'(distance), 64'd0);
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_timeout", 64'(timeout), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_scan_done", 64'(scan_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    run_scan(3'b001);
    if (timeout[0]) run_scan(3'b001);
    chk("arst_recover_valid", 64'(valid), 64'b001);
    chk("arst_recover_distance", 64'(distance[8:0]), 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/ultrasonido_scheduler.md
Name: ultrasonido_scheduler

Overview:
- Time-multiplexes one ultrasonic ranging engine (init/done/distance[8:0], trig/echo pins) across N_CH HC-SR04 sensors.
- Sensors: front/left/right on the robot.
- Each enabled channel is pinged round-robin with an inter-ping gap. Results are latched per channel for the CPU CSR bank.
- Recovers the engine from missing echoes, since the engine has no reset and otherwise hangs waiting for echo.

Parameters:
N_CH, 3, number of sensor channels (1..8)
INIT_HOLD, 200, clk cycles eng_init is held high (≥2 engine 1 MHz periods)
TIMEOUT_CYC, 3_000_000, clk cycles from init release to declare no echo (30 ms at 100 MHz)
FLUSH_CYC, 200, clk cycles eng_echo is forced high during recovery
GAP_CYC, 6_000_000, idle clk cycles between consecutive pings (60 ms)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a scan
continuous  in  1  1 = repeat scans until cleared
chan_mask  in  N_CH  enabled channels, sampled on accepted start and at each scan wrap
eng_init  out  1  to engine init
eng_done  in  1  from engine done (engine clock domain)
eng_distance  in  9  from engine distance, cm
eng_trig  in  1  from engine trig
eng_echo  out  1  to engine echo
trig  out  N_CH  sensor trigger pins
echo  in  N_CH  sensor echo pins (asynchronous)
distance  out  9*N_CH  latched distance, channel i at [9i+8:9i]
valid  out  N_CH  channel holds a fresh result from the current/last scan
timeout  out  N_CH  channel's last ping timed out
busy  out  1  scan in progress
scan_done  out  1  one-cycle pulse at end of each scan

Behaviour:
- Reset (async, rst_n=0): state IDLE; eng_init=0; eng_echo=0; trig=0; distance=0; valid=0; timeout=0; busy=0; scan_done=0; sel=0; all counters 0.
- Synchronisers: eng_done and echo[] pass through 2-flop synchronisers. A done rise is detected on the synchronised signal (previous 0, now 1).
- IDLE: start=1 → latch mask.
  - mask==0: pulse scan_done next cycle and stay IDLE.
  - Otherwise: busy=1, clear valid and timeout, sel = lowest set bit, go INIT.
  - start while busy is ignored.
- INIT: eng_init=1 for INIT_HOLD cycles, then 0; go WAIT with the timeout counter cleared.
- WAIT:
  - Synchronised done rises → distance[sel]=eng_distance, valid[sel]=1, go GAP.
  - Counter reaches TIMEOUT_CYC first → timeout[sel]=1, distance[sel] unchanged, go FLUSH.
- FLUSH: eng_echo forced 1 for FLUSH_CYC cycles, then 0; go WFLUSH.
- WFLUSH: wait for done rise or TIMEOUT_CYC, whichever comes first; discard eng_distance; go GAP.
- GAP: count GAP_CYC, then advance.
  - Next higher set bit in the latched mask exists → sel = that bit, go INIT.
  - Else the scan has ended: pulse scan_done.
    - continuous=1 → re-sample chan_mask and clear valid/timeout; mask==0 → IDLE with busy=0, else sel = lowest set bit, go INIT.
    - continuous=0 → IDLE, busy=0.
- Routing:
  - trig[i] = eng_trig when i==sel and state∈{INIT,WAIT}, else 0.
  - eng_echo = synced echo[sel] in INIT/WAIT, 1 in FLUSH, 0 elsewhere.
  - Non-selected sensors are never triggered.
- Single-channel mask: the gap still applies between repeats in continuous mode.
- Clearing continuous mid-scan finishes the current scan, then returns to IDLE.
- Reset mid-ping: outputs clear immediately. The engine may be left mid-measurement; the first ping after reset can therefore time out and FLUSH, which is acceptable.
- Distance width is 9 bits, passed unchanged; no arithmetic beyond counters.
- Counter width: $clog2(max(TIMEOUT_CYC, GAP_CYC)+1).

Decomposition:
- Shared package ultrasonido_pkg: state encoding (IDLE, INIT, WAIT, FLUSH, WFLUSH, GAP), DIST_W=9, default cycle constants.
- One natural sub-module, sync2 (2-flop synchroniser), instantiated N_CH+1 times.
- Next-channel priority search is a function in the package.
- The engine itself is instantiated outside, at SoC top level.

Test Plan:
- Bench setup: real ranging engine plus sensor models; TIMEOUT/GAP scaled down.
- mask=101, start, echo widths 580 µs (ch0) and 1160 µs (ch2) → distance ch0=10, ch2=20; valid=101; trig never on ch1; one scan_done; busy falls.
- mask=010, sensor never echoes → timeout=010; FLUSH drives eng_echo high; engine returns done, result discarded; distance ch1 stays 0; next start on ch1 with 290 µs echo → 5.
- continuous=1, mask=011 → ch0, ch1, ch0, ch1 order, scan_done each wrap, ≥GAP_CYC between trig pulses; clear continuous mid-ch0 → ch1 completes, then IDLE.
- Pulse rst_n low during WAIT → all outputs 0 asynchronously; after release, start with mask=001 completes, or times out then succeeds on the second start.
- mask=000, start → scan_done pulse next cycle, busy stays 0, no eng_init.
- start pulsed while busy → ignored, scan order and scan_done count unchanged.
